// File: rtl/alu_pkg.sv
// Shared opcode, flag-index and FSM-state definitions for the multicycle ALU.
// No logic of its own; no latency or backpressure.
package alu_pkg;

   typedef enum logic [3:0] {
      OP_ADD  = 4'b0000,
      OP_SUB  = 4'b0001,
      OP_AND  = 4'b0010,
      OP_OR   = 4'b0011,
      OP_XOR  = 4'b0100,
      OP_SHL  = 4'b0101,
      OP_SHR  = 4'b0110,
      OP_CMP  = 4'b0111,
      OP_MUL  = 4'b1000,
      OP_DIVU = 4'b1001
   } op_t;

   localparam int FLG_ZERO  = 0;
   localparam int FLG_CARRY = 1;
   localparam int FLG_OVF   = 2;
   localparam int FLG_DZ    = 3;

   typedef enum logic [1:0] {
      IDLE,
      EXEC,
      DONE
   } state_t;

endpackage

// File: rtl/alu_iter.sv
// Shift-add multiplier / restoring divider sharing one 2*WIDTH accumulator.
// WIDTH iteration cycles after start; done is combinational on the last one, lo/hi show the post-iteration value.
module alu_iter #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             is_div,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             done,
   output logic [WIDTH-1:0] lo,
   output logic [WIDTH-1:0] hi
);
   localparam int SHW = $clog2(WIDTH);

   logic [2*WIDTH-1:0] acc, acc_n;
   logic [WIDTH-1:0]   b_r;
   logic [SHW:0]       cnt;
   logic               busy, div_r;

   logic [WIDTH:0]     mul_sum;
   logic [WIDTH:0]     div_top;
   logic [WIDTH-1:0]   div_diff;
   logic               div_ge;

   // Multiply: conditionally add b into the high half, then shift right.
   assign mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, b_r} : '0);
   // Divide: the shifted partial remainder needs WIDTH+1 bits before the trial subtract.
   assign div_top  = acc[2*WIDTH-1:WIDTH-1];
   assign div_ge   = div_top >= {1'b0, b_r};
   assign div_diff = div_top[WIDTH-1:0] - b_r;

   always_comb begin
      acc_n = {mul_sum, acc[WIDTH-1:1]};
      if (div_r) begin
         if (div_ge) acc_n = {div_diff, acc[WIDTH-2:0], 1'b1};
         else        acc_n = {div_top[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
      end
   end

   assign done = busy && (cnt == (SHW+1)'(WIDTH-1));
   assign lo   = acc_n[WIDTH-1:0];
   assign hi   = acc_n[2*WIDTH-1:WIDTH];

   always_ff @(posedge clk) begin
      if (rst) begin
         acc   <= '0;
         b_r   <= '0;
         cnt   <= '0;
         busy  <= 1'b0;
         div_r <= 1'b0;
      end else if (start) begin
         acc   <= {{WIDTH{1'b0}}, a};
         b_r   <= b;
         div_r <= is_div;
         cnt   <= '0;
         busy  <= 1'b1;
      end else if (busy) begin
         acc <= acc_n;
         if (done) busy <= 1'b0;
         else      cnt  <= cnt + 1'b1;
      end
   end

endmodule

// File: rtl/alu_mc.sv
// Multicycle ALU: single-cycle ops, iterative MUL/DIVU, status flags, valid/ready both sides.
// Latency 1 cycle (WIDTH+1 for MUL/DIVU); result held in DONE until out_ready, in_ready low meanwhile.
module alu_mc
   import alu_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [3:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic [WIDTH-1:0] rem_out,
   output logic [3:0]       flags
);
   localparam int SHW = $clog2(WIDTH);

   state_t           state, state_n;
   op_t              op_in;
   logic             accept, iter_start, iter_done, div_r;
   logic [WIDTH-1:0] iter_lo, iter_hi;
   logic [WIDTH:0]   add_s;
   logic [WIDTH-1:0] sub_s;
   logic [WIDTH-1:0] sc_res, sc_rem;
   logic [3:0]       sc_flg, it_flg;

   assign op_in      = op_t'(op);
   assign accept     = in_valid && in_ready;
   // Divide by zero resolves in one cycle, so it never starts the iterator.
   assign iter_start = accept && ((op_in == OP_MUL) || ((op_in == OP_DIVU) && (b != '0)));
   assign in_ready   = (state == IDLE);
   assign out_valid  = (state == DONE);
   assign add_s      = {1'b0, a} + {1'b0, b};
   assign sub_s      = a - b;

   alu_iter #(.WIDTH(WIDTH)) u_iter (
      .clk    (clk),
      .rst    (rst),
      .start  (iter_start),
      .is_div (op_in == OP_DIVU),
      .a      (a),
      .b      (b),
      .done   (iter_done),
      .lo     (iter_lo),
      .hi     (iter_hi)
   );

   always_comb begin
      sc_res = '0;
      sc_rem = '0;
      sc_flg = '0;
      case (op_in)
         OP_ADD: begin
            sc_res           = add_s[WIDTH-1:0];
            sc_flg[FLG_CARRY] = add_s[WIDTH];
            sc_flg[FLG_OVF]   = (a[WIDTH-1] == b[WIDTH-1]) && (add_s[WIDTH-1] != a[WIDTH-1]);
         end
         OP_SUB: begin
            sc_res           = sub_s;
            sc_flg[FLG_CARRY] = a < b;
            sc_flg[FLG_OVF]   = (a[WIDTH-1] != b[WIDTH-1]) && (sub_s[WIDTH-1] != a[WIDTH-1]);
         end
         OP_AND: sc_res = a & b;
         OP_OR:  sc_res = a | b;
         OP_XOR: sc_res = a ^ b;
         OP_SHL: sc_res = a << b[SHW-1:0];
         OP_SHR: sc_res = a >> b[SHW-1:0];
         OP_CMP: sc_res = (a == b) ? WIDTH'(0) : ((a > b) ? WIDTH'(1) : WIDTH'(2));
         OP_DIVU: begin
            sc_res         = '1;
            sc_rem         = a;
            sc_flg[FLG_DZ] = 1'b1;
         end
         default: sc_res = '0;
      endcase
      sc_flg[FLG_ZERO] = (sc_res == '0);
   end

   always_comb begin
      it_flg           = '0;
      it_flg[FLG_ZERO] = (iter_lo == '0);
      it_flg[FLG_OVF]  = !div_r && (iter_hi != '0);
   end

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_n;
   end

   always_comb begin
      state_n = state;
      case (state)
         IDLE:    if (accept) state_n = iter_start ? EXEC : DONE;
         EXEC:    if (iter_done) state_n = DONE;
         DONE:    if (out_ready) state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         result  <= '0;
         rem_out <= '0;
         flags   <= '0;
         div_r   <= 1'b0;
      end else if (accept) begin
         div_r <= (op_in == OP_DIVU);
         if (!iter_start) begin
            result  <= sc_res;
            rem_out <= sc_rem;
            flags   <= sc_flg;
         end
      end else if ((state == EXEC) && iter_done) begin
         result  <= iter_lo;
         rem_out <= div_r ? iter_hi : '0;
         flags   <= it_flg;
      end
   end

endmodule

// File: tb/tb_alu_mc.sv
// Directed bench for alu_mc at WIDTH=16 with a queue of expected results.
module tb_alu_mc;

   typedef struct packed {
      logic [15:0] res;
      logic [15:0] rem;
      logic [3:0]  flg;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [3:0]  op = 4'd0;
   logic [15:0] a = 16'd0;
   logic [15:0] b = 16'd0;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic [15:0] result;
   logic [15:0] rem_out;
   logic [3:0]  flags;

   int   tests = 0;
   int   fails = 0;
   exp_t sb[$];

   alu_mc #(.WIDTH(16)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .op        (op),
      .a         (a),
      .b         (b),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result),
      .rem_out   (rem_out),
      .flags     (flags)
   );

   always #5 clk = ~clk;

   function automatic exp_t model(input logic [3:0] o, input logic [15:0] x, input logic [15:0] y);
      exp_t        e;
      logic [31:0] w;
      int          sx, sy, sr;
      e  = '0;
      sx = $signed(x);
      sy = $signed(y);
      case (o)
         4'd0: begin
            w = {16'd0, x} + {16'd0, y};
            e.res = w[15:0];
            e.flg[1] = w[16];
            sr = sx + sy;
            e.flg[2] = (sr > 32767) || (sr < -32768);
         end
         4'd1: begin
            e.res = x - y;
            e.flg[1] = (x < y);
            sr = sx - sy;
            e.flg[2] = (sr > 32767) || (sr < -32768);
         end
         4'd2: e.res = x & y;
         4'd3: e.res = x | y;
         4'd4: e.res = x ^ y;
         4'd5: e.res = x << y[3:0];
         4'd6: e.res = x >> y[3:0];
         4'd7: e.res = (x == y) ? 16'd0 : ((x > y) ? 16'd1 : 16'd2);
         4'd8: begin
            w = {16'd0, x} * {16'd0, y};
            e.res = w[15:0];
            e.flg[2] = (w[31:16] != 16'd0);
         end
         4'd9: begin
            if (y == 16'd0) begin
               e.res = 16'hFFFF;
               e.rem = x;
               e.flg[3] = 1'b1;
            end else begin
               e.res = x / y;
               e.rem = x % y;
            end
         end
         default: e.res = 16'd0;
      endcase
      e.flg[0] = (e.res == 16'd0);
      return e;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      tests++;
      assert (obs === expv) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   // Entered #1 after an edge; leaves #1 after the accept edge.
   task automatic issue(input logic [3:0] o, input logic [15:0] x, input logic [15:0] y);
      int n;
      n = 0;
      while (in_ready !== 1'b1 && n < 50) begin
         @(posedge clk); #1;
         n++;
      end
      check("issue_ready", {31'd0, in_ready}, 32'd1);
      op = o; a = x; b = y;
      in_valid = 1'b1;
      sb.push_back(model(o, x, y));
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   task automatic collect(input int exp_lat, input string tag);
      int   lat;
      logic busy_ok;
      exp_t e;
      lat = 1;
      busy_ok = 1'b1;
      while (out_valid !== 1'b1 && lat < 100) begin
         if (in_ready !== 1'b0) busy_ok = 1'b0;
         @(posedge clk); #1;
         lat++;
      end
      check({tag, "_lat"}, lat, exp_lat);
      check({tag, "_busy"}, {31'd0, busy_ok}, 32'd1);
      if (sb.size() == 0) begin
         check({tag, "_sb_empty"}, 32'd0, 32'd1);
      end else begin
         e = sb.pop_front();
         check({tag, "_res"}, {16'd0, result}, {16'd0, e.res});
         check({tag, "_rem"}, {16'd0, rem_out}, {16'd0, e.rem});
         check({tag, "_flg"}, {28'd0, flags}, {28'd0, e.flg});
      end
   endtask

   task automatic run(input logic [3:0] o, input logic [15:0] x, input logic [15:0] y,
                      input int exp_lat, input string tag);
      issue(o, x, y);
      collect(exp_lat, tag);
      @(posedge clk); #1;
   endtask

   initial begin
      logic [3:0]  ro;
      logic [15:0] ra, rb;

      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      @(posedge clk); #1;
      check("rst_in_ready", {31'd0, in_ready}, 32'd1);
      check("rst_out_valid", {31'd0, out_valid}, 32'd0);
      check("rst_result", {16'd0, result}, 32'd0);
      check("rst_rem", {16'd0, rem_out}, 32'd0);
      check("rst_flags", {28'd0, flags}, 32'd0);

      run(4'd0, 16'hFFFF, 16'h0001, 1, "add_wrap");
      check("add_wrap_flags_const", {28'd0, flags}, 32'h3);
      run(4'd5, 16'h0001, 16'h0013, 1, "shl");
      check("shl_const", {16'd0, result}, 32'h8);
      run(4'd7, 16'd5, 16'd9, 1, "cmp_lt");
      run(4'd7, 16'd9, 16'd5, 1, "cmp_gt");
      run(4'd7, 16'd7, 16'd7, 1, "cmp_eq");
      run(4'd1, 16'd3, 16'd5, 1, "sub_borrow");
      run(4'd1, 16'h8000, 16'h0001, 1, "sub_ovf");
      run(4'd0, 16'h7FFF, 16'h0001, 1, "add_ovf");
      run(4'd2, 16'hF0F0, 16'h3C3C, 1, "and");
      run(4'd3, 16'hF0F0, 16'h0F0F, 1, "or");
      run(4'd4, 16'hAAAA, 16'hAAAA, 1, "xor");
      run(4'd6, 16'h8000, 16'h001F, 1, "shr");
      run(4'd12, 16'h1234, 16'h5678, 1, "bad_op");

      run(4'd8, 16'h0100, 16'h0100, 17, "mul_ovf");
      check("mul_ovf_flags_const", {28'd0, flags}, 32'h5);
      run(4'd8, 16'h00FF, 16'h00FF, 17, "mul");
      run(4'd9, 16'd100, 16'd7, 17, "divu");
      check("divu_const", {result, rem_out}, {16'd14, 16'd2});
      run(4'd9, 16'hFFFF, 16'd3, 17, "divu_big");
      run(4'd9, 16'h8001, 16'h8000, 17, "divu_top");
      run(4'd9, 16'h1234, 16'd0, 1, "divu_zero");
      check("divu_zero_flags_const", {28'd0, flags}, 32'h8);

      for (int i = 0; i < 8; i++) begin
         ro = 4'($urandom_range(0, 9));
         ra = 16'($urandom);
         rb = 16'($urandom);
         run(ro, ra, rb, (ro == 4'd8 || (ro == 4'd9 && rb != 16'd0)) ? 17 : 1, "rand");
      end

      // Backpressure: DONE must hold and ignore new offers.
      out_ready = 1'b0;
      issue(4'd0, 16'h1111, 16'h2222);
      collect(1, "hold");
      for (int i = 0; i < 5; i++) begin
         in_valid = 1'b1;
         op = 4'd4;
         a = 16'($urandom);
         b = 16'($urandom);
         @(posedge clk); #1;
         check("hold_res", {16'd0, result}, 32'h3333);
         check("hold_flg", {28'd0, flags}, 32'h0);
         check("hold_vld", {30'd0, out_valid, in_ready}, 32'h2);
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      @(posedge clk); #1;
      check("hold_release", {30'd0, out_valid, in_ready}, 32'h1);

      // Reset in the middle of a multiply.
      issue(4'd8, 16'h1234, 16'h5678);
      repeat (3) begin
         @(posedge clk); #1;
      end
      rst = 1'b1;
      @(posedge clk); #1;
      check("midrst_vld", {30'd0, out_valid, in_ready}, 32'h1);
      check("midrst_out", {result, rem_out}, 32'h0);
      check("midrst_flg", {28'd0, flags}, 32'h0);
      sb.delete();
      rst = 1'b0;
      @(posedge clk); #1;
      run(4'd0, 16'd2, 16'd3, 1, "post_rst_add");
      check("post_rst_add_const", {16'd0, result}, 32'd5);
      check("sb_drained", sb.size(), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end

endmodule
